axis_ramp_checker: RTL and testbench

AXIS_RAMP_CHECKER -- requirements
Module: axis_ramp_checker

---
 rtl/axis_ramp_pkg.sv | 19 +
 rtl/axis_ramp_gen.sv | 54 +++++
 rtl/axis_ramp_checker.sv | 185 ++++++++++++++++++
 tb/tb_axis_ramp_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_ramp_pkg.sv
// Shared definitions for the AXI-Stream ramp checker and its expected-beat generator.
package axis_ramp_pkg;

    typedef enum logic {
        ST_CHECK = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam int unsigned ERR_W     = 4;
    localparam int unsigned ERR_DATA  = 0;
    localparam int unsigned ERR_KEEP  = 1;
    localparam int unsigned ERR_EARLY = 2;
    localparam int unsigned ERR_MISS  = 3;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/axis_ramp_gen.sv
// Expected beat of a ramp packet: data, keep and last-line flag for a given size and line index.
module axis_ramp_gen
    import axis_ramp_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned NWORDS = 4,
    parameter int unsigned SIZE_W = 7,
    parameter int unsigned LINE_W = 5
) (
    input  logic [SIZE_W-1:0]        size_i,
    input  logic [LINE_W-1:0]        line_i,
    output logic [WORD_W*NWORDS-1:0] data_o,
    output logic [NWORDS-1:0]        keep_o,
    output logic                     last_line_o
);

    logic [31:0] size_ext_s;
    logic [31:0] line_ext_s;
    logic [31:0] lines_s;
    logic [31:0] residue_s;
    logic [31:0] word_s;

    // Line count and partial-line residue derived from the packet size
    always_comb begin
        size_ext_s  = 32'(size_i);
        line_ext_s  = 32'(line_i);
        lines_s     = ceil_div(size_ext_s, NWORDS);
        residue_s   = size_ext_s % NWORDS;
        last_line_o = (line_ext_s == (lines_s - 32'd1));
    end

    // Ramp value of each lane, truncated to the word width
    always_comb begin
        data_o = '0;
        word_s = 32'd0;
        for (int p = 0; p < NWORDS; p++) begin
            word_s = (line_ext_s * NWORDS) + 32'(p);
            data_o[p*WORD_W +: WORD_W] = word_s[WORD_W-1:0];
        end
    end

    // Only a partial last line drops its upper lanes
    always_comb begin
        keep_o = '1;
        if (last_line_o && (residue_s != 32'd0)) begin
            for (int p = 0; p < NWORDS; p++) begin
                keep_o[p] = (32'(p) < residue_s);
            end
        end else begin
            keep_o = '1;
        end
    end

endmodule

// File: rtl/axis_ramp_checker.sv
// Checks an AXI-Stream of ramp packets whose sizes step 1..MAX_SPP, reporting sticky errors and counts.
module axis_ramp_checker
    import axis_ramp_pkg::*;
#(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned NWORDS  = 4,
    parameter int unsigned MAX_SPP = 100
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [WORD_W*NWORDS-1:0]         s_axis_tdata,
    input  logic [NWORDS-1:0]                s_axis_tkeep,
    input  logic                             s_axis_tlast,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic                             pkt_done,
    output logic [3:0]                       err_flags,
    output logic [$clog2(MAX_SPP+1)-1:0]     err_size,
    output logic [31:0]                      pkt_cnt,
    output logic [15:0]                      err_cnt
);

    localparam int unsigned SIZE_W    = $clog2(MAX_SPP + 1);
    localparam int unsigned MAX_LINES = ceil_div(MAX_SPP, NWORDS);
    localparam int unsigned LINE_W    = $clog2(MAX_LINES + 1);

    localparam logic [SIZE_W-1:0] SIZE_ONE = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(MAX_SPP);

    state_e              state_q,     state_d;
    logic [LINE_W-1:0]   line_q,      line_d;
    logic [SIZE_W-1:0]   size_q,      size_d;
    logic                pkt_err_q,   pkt_err_d;
    logic                pkt_done_q,  pkt_done_d;
    logic [ERR_W-1:0]    err_flags_q, err_flags_d;
    logic [SIZE_W-1:0]   err_size_q,  err_size_d;
    logic [31:0]         pkt_cnt_q,   pkt_cnt_d;
    logic [15:0]         err_cnt_q,   err_cnt_d;

    logic [WORD_W*NWORDS-1:0] exp_data_s;
    logic [NWORDS-1:0]        exp_keep_s;
    logic                     exp_last_s;
    logic                     accept_s;
    logic                     data_bad_s;
    logic                     keep_bad_s;
    logic                     finish_s;
    logic [ERR_W-1:0]         beat_err_s;

    axis_ramp_gen #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .SIZE_W (SIZE_W),
        .LINE_W (LINE_W)
    ) u_gen (
        .size_i      (size_q),
        .line_i      (line_q),
        .data_o      (exp_data_s),
        .keep_o      (exp_keep_s),
        .last_line_o (exp_last_s)
    );

    // Both states accept whenever enabled; reset drops ready immediately.
    assign s_axis_tready = en & ~rst;
    assign accept_s      = s_axis_tvalid & s_axis_tready;

    // Lane-wise comparison against the expected beat; data only where keep is expected
    always_comb begin
        data_bad_s = 1'b0;
        for (int p = 0; p < NWORDS; p++) begin
            data_bad_s = data_bad_s |
                (exp_keep_s[p] & (s_axis_tdata[p*WORD_W +: WORD_W] != exp_data_s[p*WORD_W +: WORD_W]));
        end
        keep_bad_s = (s_axis_tkeep != exp_keep_s);
    end

    // Packet framing state machine and error/count bookkeeping
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        size_d      = size_q;
        pkt_err_d   = pkt_err_q;
        pkt_done_d  = 1'b0;
        err_flags_d = err_flags_q;
        err_size_d  = err_size_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        finish_s    = 1'b0;
        beat_err_s  = '0;

        if (accept_s) begin
            case (state_q)
                ST_CHECK: begin
                    beat_err_s[ERR_DATA] = data_bad_s;
                    beat_err_s[ERR_KEEP] = keep_bad_s;
                    if (exp_last_s) begin
                        if (s_axis_tlast) begin
                            finish_s = 1'b1;
                        end else begin
                            beat_err_s[ERR_MISS] = 1'b1;
                            state_d              = ST_DRAIN;
                            line_d               = '0;
                        end
                    end else begin
                        if (s_axis_tlast) begin
                            beat_err_s[ERR_EARLY] = 1'b1;
                            finish_s              = 1'b1;
                        end else begin
                            line_d = line_q + LINE_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_tlast) begin
                        finish_s = 1'b1;
                        state_d  = ST_CHECK;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_CHECK;
                    line_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        err_flags_d = err_flags_q | beat_err_s;
        // The first erroneous packet is the one seen while no flag is yet set
        if ((err_flags_q == '0) && (beat_err_s != '0)) begin
            err_size_d = size_q;
        end else begin
            err_size_d = err_size_q;
        end

        if (finish_s) begin
            line_d     = '0;
            size_d     = (size_q == SIZE_MAX) ? SIZE_ONE : (size_q + SIZE_ONE);
            pkt_done_d = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            pkt_err_d  = 1'b0;
            if ((pkt_err_q || (beat_err_s != '0)) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            pkt_err_d = pkt_err_q | (beat_err_s != '0);
        end
    end

    // State and output registers; everything freezes while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CHECK;
            line_q      <= '0;
            size_q      <= SIZE_ONE;
            pkt_err_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_flags_q <= '0;
            err_size_q  <= '0;
            pkt_cnt_q   <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else if (en) begin
            state_q     <= state_d;
            line_q      <= line_d;
            size_q      <= size_d;
            pkt_err_q   <= pkt_err_d;
            pkt_done_q  <= pkt_done_d;
            err_flags_q <= err_flags_d;
            err_size_q  <= err_size_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pkt_done  = pkt_done_q;
    assign err_flags = err_flags_q;
    assign err_size  = err_size_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axis_ramp_checker.sv
// Directed bench for axis_ramp_checker with WORD_W=8, NWORDS=4, MAX_SPP=8.
module tb_axis_ramp_checker;
    import axis_ramp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] tdata = 32'd0;
    logic [3:0]  tkeep = 4'd0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        pkt_done;
    logic [3:0]  err_flags;
    logic [3:0]  err_size;
    logic [31:0] pkt_cnt;
    logic [15:0] err_cnt;

    int vec_cnt = 0;
    int mis_cnt = 0;
    int done_cnt = 0;

    axis_ramp_checker #(.WORD_W(8), .NWORDS(4), .MAX_SPP(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tlast  (tlast),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .pkt_done      (pkt_done),
        .err_flags     (err_flags),
        .err_size      (err_size),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ramp_data(input int l);
        logic [31:0] d;
        for (int p = 0; p < 4; p++) d[p*8 +: 8] = 8'(l*4 + p);
        return d;
    endfunction

    function automatic logic [3:0] ramp_keep(input int n, input int l);
        int lines = (n + 3) / 4;
        int res = n % 4;
        if (l == lines - 1 && res != 0) return 4'((1 << res) - 1);
        return 4'hF;
    endfunction

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic last);
        @(negedge clk);
        tdata = d; tkeep = k; tlast = last; tvalid = 1'b1;
    endtask

    task automatic beat_rand(input logic [31:0] d, input logic [3:0] k, input logic last);
        int guard = 0;
        forever begin
            @(negedge clk);
            tdata = d; tkeep = k; tlast = last;
            en = ($urandom_range(0, 3) != 0);
            tvalid = ($urandom_range(0, 2) != 0);
            guard++;
            if (guard > 50) begin en = 1'b1; tvalid = 1'b1; end
            if (en && tvalid) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0; tlast = 1'b0;
        end
    endtask

    task automatic send_pkt(input int n, input bit gaps);
        int lines = (n + 3) / 4;
        for (int l = 0; l < lines; l++) begin
            if (gaps) beat_rand(ramp_data(l), ramp_keep(n, l), l == lines - 1);
            else      beat(ramp_data(l), ramp_keep(n, l), l == lines - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; en = 1'b1; rst = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        en = 1'b1;
        @(negedge clk);
        vec_cnt++; if (tready !== 1'b0) begin mis_cnt++; $display("FAIL rst_tready: got %b want 0", tready); end
        vec_cnt++; if (pkt_done !== 1'b0) begin mis_cnt++; $display("FAIL rst_pkt_done: got %b want 0", pkt_done); end
        vec_cnt++; if (err_flags !== 4'b0000) begin mis_cnt++; $display("FAIL rst_err_flags: got %b want 0000", err_flags); end
        vec_cnt++; if (err_size !== 4'd0) begin mis_cnt++; $display("FAIL rst_err_size: got %0d want 0", err_size); end
        vec_cnt++; if (pkt_cnt !== 32'd0) begin mis_cnt++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
        vec_cnt++; if (err_cnt !== 16'd0) begin mis_cnt++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        rst = 1'b0;
        #1;
        vec_cnt++; if (tready !== 1'b1) begin mis_cnt++; $display("FAIL rel_tready: got %b want 1", tready); end
        idle(1);
    endtask

    task automatic test_sweep();
        do_reset();
        for (int n = 1; n <= 8; n++) send_pkt(n, 1'b0);
        send_pkt(1, 1'b0);
        idle(2);
        vec_cnt++; if (pkt_cnt !== 32'd9) begin mis_cnt++; $display("FAIL sweep_pkt_cnt: got %0d want 9", pkt_cnt); end
        vec_cnt++; if (err_cnt !== 16'd0) begin mis_cnt++; $display("FAIL sweep_err_cnt: got %0d want 0", err_cnt); end
        vec_cnt++; if (err_flags !== 4'b0000) begin mis_cnt++; $display("FAIL sweep_err_flags: got %b want 0000", err_flags); end
        vec_cnt++; if (done_cnt !== 9) begin mis_cnt++; $display("FAIL sweep_done_pulses: got %0d want 9", done_cnt); end
    endtask

    task automatic test_data_err();
        logic [31:0] d;
        do_reset();
        send_pkt(1, 1'b0);
        send_pkt(2, 1'b0);
        d = ramp_data(0);
        d[15:8] = 8'h55;
        beat(d, 4'b0111, 1'b1);
        idle(2);
        vec_cnt++; if (err_flags !== 4'b0001) begin mis_cnt++; $display("FAIL data_flags: got %b want 0001", err_flags); end
        vec_cnt++; if (err_size !== 4'd3) begin mis_cnt++; $display("FAIL data_err_size: got %0d want 3", err_size); end
        vec_cnt++; if (err_cnt !== 16'd1) begin mis_cnt++; $display("FAIL data_err_cnt: got %0d want 1", err_cnt); end
        send_pkt(4, 1'b0);
        idle(2);
        vec_cnt++; if (err_cnt !== 16'd1) begin mis_cnt++; $display("FAIL data_next_err_cnt: got %0d want 1", err_cnt); end
        vec_cnt++; if (pkt_cnt !== 32'd4) begin mis_cnt++; $display("FAIL data_next_pkt_cnt: got %0d want 4", pkt_cnt); end
        vec_cnt++; if (err_flags !== 4'b0001) begin mis_cnt++; $display("FAIL data_next_flags: got %b want 0001", err_flags); end
    endtask

    task automatic test_keep_err();
        do_reset();
        for (int n = 1; n <= 4; n++) send_pkt(n, 1'b0);
        beat(ramp_data(0), 4'hF, 1'b0);
        beat(ramp_data(1), 4'b0011, 1'b1);
        idle(2);
        vec_cnt++; if (err_flags !== 4'b0010) begin mis_cnt++; $display("FAIL keep_flags: got %b want 0010", err_flags); end
        vec_cnt++; if (err_size !== 4'd5) begin mis_cnt++; $display("FAIL keep_err_size: got %0d want 5", err_size); end
        vec_cnt++; if (err_cnt !== 16'd1) begin mis_cnt++; $display("FAIL keep_err_cnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_early_last();
        do_reset();
        for (int n = 1; n <= 5; n++) send_pkt(n, 1'b0);
        beat(ramp_data(0), 4'hF, 1'b1);
        idle(2);
        vec_cnt++; if (err_flags !== 4'b0100) begin mis_cnt++; $display("FAIL early_flags: got %b want 0100", err_flags); end
        vec_cnt++; if (err_size !== 4'd6) begin mis_cnt++; $display("FAIL early_err_size: got %0d want 6", err_size); end
        vec_cnt++; if (pkt_cnt !== 32'd6) begin mis_cnt++; $display("FAIL early_pkt_cnt: got %0d want 6", pkt_cnt); end
        send_pkt(7, 1'b0);
        idle(2);
        vec_cnt++; if (err_flags !== 4'b0100) begin mis_cnt++; $display("FAIL early_next7_flags: got %b want 0100", err_flags); end
        vec_cnt++; if (err_cnt !== 16'd1) begin mis_cnt++; $display("FAIL early_next7_err_cnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_missing_last();
        do_reset();
        send_pkt(1, 1'b0);
        idle(2);
        done_cnt = 0;
        beat(ramp_data(0), 4'b0011, 1'b0);
        idle(1);
        vec_cnt++; if (dut.state_q !== ST_DRAIN) begin mis_cnt++; $display("FAIL miss_state: got %0d want DRAIN", dut.state_q); end
        vec_cnt++; if (err_flags !== 4'b1000) begin mis_cnt++; $display("FAIL miss_flags: got %b want 1000", err_flags); end
        vec_cnt++; if (err_cnt !== 16'd0) begin mis_cnt++; $display("FAIL miss_err_cnt_mid: got %0d want 0", err_cnt); end
        beat(32'hDEADBEEF, 4'b0101, 1'b0);
        beat(32'h12345678, 4'b1111, 1'b0);
        beat(32'hCAFEF00D, 4'b0001, 1'b1);
        idle(2);
        vec_cnt++; if (done_cnt !== 1) begin mis_cnt++; $display("FAIL miss_done_pulses: got %0d want 1", done_cnt); end
        vec_cnt++; if (err_size !== 4'd2) begin mis_cnt++; $display("FAIL miss_err_size: got %0d want 2", err_size); end
        vec_cnt++; if (err_cnt !== 16'd1) begin mis_cnt++; $display("FAIL miss_err_cnt: got %0d want 1", err_cnt); end
        vec_cnt++; if (pkt_cnt !== 32'd2) begin mis_cnt++; $display("FAIL miss_pkt_cnt: got %0d want 2", pkt_cnt); end
        send_pkt(3, 1'b0);
        idle(2);
        vec_cnt++; if (err_cnt !== 16'd1) begin mis_cnt++; $display("FAIL miss_next3_err_cnt: got %0d want 1", err_cnt); end
        vec_cnt++; if (err_flags !== 4'b1000) begin mis_cnt++; $display("FAIL miss_next3_flags: got %b want 1000", err_flags); end
        vec_cnt++; if (pkt_cnt !== 32'd3) begin mis_cnt++; $display("FAIL miss_next3_pkt_cnt: got %0d want 3", pkt_cnt); end
    endtask

    task automatic test_en_hold();
        do_reset();
        en = 1'b0;
        beat(ramp_data(0), 4'b0001, 1'b1);
        #1;
        vec_cnt++; if (tready !== 1'b0) begin mis_cnt++; $display("FAIL hold_tready: got %b want 0", tready); end
        repeat (3) @(negedge clk);
        vec_cnt++; if (pkt_cnt !== 32'd0) begin mis_cnt++; $display("FAIL hold_pkt_cnt: got %0d want 0", pkt_cnt); end
        en = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        en = 1'b0;
        vec_cnt++; if (pkt_done !== 1'b1) begin mis_cnt++; $display("FAIL hold_done_rise: got %b want 1", pkt_done); end
        repeat (2) @(negedge clk);
        vec_cnt++; if (pkt_done !== 1'b1) begin mis_cnt++; $display("FAIL hold_done_held: got %b want 1", pkt_done); end
        vec_cnt++; if (pkt_cnt !== 32'd1) begin mis_cnt++; $display("FAIL hold_pkt_cnt_after: got %0d want 1", pkt_cnt); end
        en = 1'b1;
        idle(2);
        vec_cnt++; if (pkt_done !== 1'b0) begin mis_cnt++; $display("FAIL hold_done_clear: got %b want 0", pkt_done); end
    endtask

    task automatic test_gaps_reset();
        do_reset();
        for (int k = 0; k < 24; k++) send_pkt((k % 8) + 1, 1'b1);
        en = 1'b1;
        idle(2);
        vec_cnt++; if (pkt_cnt !== 32'd24) begin mis_cnt++; $display("FAIL gaps_pkt_cnt: got %0d want 24", pkt_cnt); end
        vec_cnt++; if (err_flags !== 4'b0000) begin mis_cnt++; $display("FAIL gaps_flags: got %b want 0000", err_flags); end
        vec_cnt++; if (err_cnt !== 16'd0) begin mis_cnt++; $display("FAIL gaps_err_cnt: got %0d want 0", err_cnt); end
        for (int n = 1; n <= 4; n++) send_pkt(n, 1'b0);
        beat(ramp_data(0), 4'hF, 1'b0);
        @(negedge clk);
        tvalid = 1'b0;
        vec_cnt++; if (pkt_cnt !== 32'd28) begin mis_cnt++; $display("FAIL pre_rst_pkt_cnt: got %0d want 28", pkt_cnt); end
        #2 rst = 1'b1;
        #1;
        vec_cnt++; if (tready !== 1'b0) begin mis_cnt++; $display("FAIL mid_rst_tready: got %b want 0", tready); end
        vec_cnt++; if (pkt_cnt !== 32'd0) begin mis_cnt++; $display("FAIL mid_rst_pkt_cnt: got %0d want 0", pkt_cnt); end
        vec_cnt++; if (pkt_done !== 1'b0) begin mis_cnt++; $display("FAIL mid_rst_pkt_done: got %b want 0", pkt_done); end
        vec_cnt++; if ({err_flags, err_size, err_cnt} !== 24'd0) begin mis_cnt++; $display("FAIL mid_rst_errs: got %h want 0", {err_flags, err_size, err_cnt}); end
        @(negedge clk);
        rst = 1'b0;
        send_pkt(1, 1'b0);
        send_pkt(2, 1'b0);
        idle(2);
        vec_cnt++; if (pkt_cnt !== 32'd2) begin mis_cnt++; $display("FAIL post_rst_pkt_cnt: got %0d want 2", pkt_cnt); end
        vec_cnt++; if (err_flags !== 4'b0000) begin mis_cnt++; $display("FAIL post_rst_flags: got %b want 0000", err_flags); end
        vec_cnt++; if (err_cnt !== 16'd0) begin mis_cnt++; $display("FAIL post_rst_err_cnt: got %0d want 0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_data_err();
        test_keep_err();
        test_early_last();
        test_missing_last();
        test_en_hold();
        test_gaps_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
